// File: rtl/axi_to_umi.sv
// -----------------------------------------------------------------------------
// axi_to_umi
//   AXI write slave that turns exactly one AXI write (AW + W) into one UMI
//   write-normal request packet.  The AXI B response is returned only after
//   the UMI packet has been accepted downstream, or at once with SLVERR when
//   the write strobes are not all ones.  Only one transaction is in flight at
//   a time.  There are no bursts and no read channel.
//
//   Ports
//     clk, rst_n      clock and synchronous active-low reset
//     axi_aw*         write address channel: valid/ready/addr
//     axi_w*          write data channel: valid/ready/data/strb
//     axi_b*          write response channel: valid/ready/resp
//     umi_packet      request packet, combinational from the capture registers
//     umi_valid/ready request handshake
//
//   Packet layout, from LSB to MSB: {data, srcaddr, dstaddr, cmd}
//     cmd[4:0]   opcode (write-normal = 5'h03)
//     cmd[7:5]   size
//     cmd[15:8]  len (0 = single beat)
//     cmd[24:23] user
//     All other cmd bits are zero.
// -----------------------------------------------------------------------------

// Assembles the UMI command word and concatenates it with the address and
// data fields.  The module contains only combinational logic.
module umi_pack #(
   parameter int AW = 64,
   parameter int DW = 256
) (
   input  logic [4:0]             cmd_opcode,
   input  logic [2:0]             cmd_size,
   input  logic [7:0]             cmd_len,
   input  logic [1:0]             cmd_user,
   input  logic [AW-1:0]          dstaddr,
   input  logic [AW-1:0]          srcaddr,
   input  logic [DW-1:0]          data,
   output logic [DW+2*AW+31:0]    packet
);
   logic [31:0] cmd;

   assign cmd    = {7'h0, cmd_user, 7'h0, cmd_len, cmd_size, cmd_opcode};
   assign packet = {data, srcaddr, dstaddr, cmd};
endmodule

module axi_to_umi #(
   parameter int              AW      = 64,
   parameter int              DW      = 256,
   parameter logic [AW-1:0]   SRCADDR = '0,
   parameter logic [2:0]      SIZE    = 3'd5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   axi_awvalid,
   output logic                   axi_awready,
   input  logic [AW-1:0]          axi_awaddr,
   input  logic                   axi_wvalid,
   output logic                   axi_wready,
   input  logic [DW-1:0]          axi_wdata,
   input  logic [DW/8-1:0]        axi_wstrb,
   output logic                   axi_bvalid,
   input  logic                   axi_bready,
   output logic [1:0]             axi_bresp,
   output logic [DW+2*AW+31:0]    umi_packet,
   output logic                   umi_valid,
   input  logic                   umi_ready
);
   localparam logic [4:0] OPC_WRITE = 5'h03;

   typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

   state_t            state_q, state_d;
   logic              aw_have_q, aw_have_d;
   logic              w_have_q, w_have_d;
   logic [AW-1:0]     awaddr_q, awaddr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW/8-1:0]   wstrb_q, wstrb_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              umi_valid_q, umi_valid_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;

   always_comb begin
      state_d     = state_q;
      aw_have_d   = aw_have_q;
      w_have_d    = w_have_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awready_d   = 1'b0;
      wready_d    = 1'b0;
      umi_valid_d = umi_valid_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;

      case (state_q)
         IDLE: begin
            if (axi_awvalid && awready_q) begin
               aw_have_d = 1'b1;
               awaddr_d  = axi_awaddr;
            end
            if (axi_wvalid && wready_q) begin
               w_have_d = 1'b1;
               wdata_d  = axi_wdata;
               wstrb_d  = axi_wstrb;
            end
            // Each ready is cleared in the cycle after its own capture.
            awready_d = !aw_have_d;
            wready_d  = !w_have_d;
            // The strobe check uses the next-state values. This lets a
            // capture that completes the pair act in the same cycle.
            if (aw_have_d && w_have_d) begin
               if (&wstrb_d) begin
                  state_d     = SEND;
                  umi_valid_d = 1'b1;
               end else begin
                  state_d  = RESP;
                  bvalid_d = 1'b1;
                  bresp_d  = 2'b10;
               end
            end
         end
         SEND: begin
            if (umi_ready) begin
               state_d     = RESP;
               umi_valid_d = 1'b0;
               bvalid_d    = 1'b1;
               bresp_d     = 2'b00;
            end
         end
         RESP: begin
            // The readies stay low here. They come back through IDLE one
            // cycle after the B handshake.
            if (axi_bready) begin
               state_d   = IDLE;
               bvalid_d  = 1'b0;
               aw_have_d = 1'b0;
               w_have_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         aw_have_q   <= 1'b0;
         w_have_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         umi_valid_q <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         aw_have_q   <= aw_have_d;
         w_have_q    <= w_have_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         umi_valid_q <= umi_valid_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
      end
   end

   assign axi_awready = awready_q;
   assign axi_wready  = wready_q;
   assign axi_bvalid  = bvalid_q;
   assign axi_bresp   = bresp_q;
   assign umi_valid   = umi_valid_q;

   umi_pack #(
      .AW (AW),
      .DW (DW)
   ) u_pack (
      .cmd_opcode (OPC_WRITE),
      .cmd_size   (SIZE),
      .cmd_len    (8'h00),
      .cmd_user   (2'b00),
      .dstaddr    (awaddr_q),
      .srcaddr    (SRCADDR),
      .data       (wdata_q),
      .packet     (umi_packet)
   );
endmodule

// File: tb/tb_axi_to_umi.sv
module tb_axi_to_umi;
   localparam int AW = 64;
   localparam int DW = 256;
   localparam int PW = DW + 2*AW + 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              axi_awvalid;
   logic              axi_awready;
   logic [AW-1:0]     axi_awaddr;
   logic              axi_wvalid;
   logic              axi_wready;
   logic [DW-1:0]     axi_wdata;
   logic [DW/8-1:0]   axi_wstrb;
   logic              axi_bvalid;
   logic              axi_bready;
   logic [1:0]        axi_bresp;
   logic [PW-1:0]     umi_packet;
   logic              umi_valid;
   logic              umi_ready;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_to_umi dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_awaddr  (axi_awaddr),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready),
      .axi_bresp   (axi_bresp),
      .umi_packet  (umi_packet),
      .umi_valid   (umi_valid),
      .umi_ready   (umi_ready)
   );

   // Expected packet: {data, srcaddr=0, dstaddr, cmd}.
   // cmd = opcode 3 | size 5 << 5 = 32'hA3.
   function automatic logic [PW-1:0] pkt(input logic [AW-1:0] a, input logic [DW-1:0] d);
      return {d, 64'h0, a, 32'h0000_00A3};
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      axi_awvalid = 1'b1;
      axi_awaddr  = a;
      axi_wvalid  = 1'b1;
      axi_wdata   = d;
      tick();
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      $display("write addr=%h strb=%h issued", a, axi_wstrb);
   endtask

   // Performs the B handshake, then checks that the readies return 2 cycles later.
   task automatic finish_b(input string tag);
      axi_bready = 1'b1;
      tick();
      axi_bready = 1'b0;
      chk({tag, "_bvalid_drop"}, 512'(axi_bvalid), 512'(1'b0));
      chk({tag, "_awready_k1"}, 512'(axi_awready), 512'(1'b0));
      tick();
      chk({tag, "_awready_k2"}, 512'(axi_awready), 512'(1'b1));
      chk({tag, "_wready_k2"}, 512'(axi_wready), 512'(1'b1));
      $display("B handshake done (%s)", tag);
   endtask

   // umi_valid and bvalid must never be high together.
   always @(negedge clk) begin
      if (rst_n === 1'b1)
         chk("excl_valid", 512'(umi_valid & axi_bvalid), 512'(1'b0));
   end

   initial begin
      logic [DW-1:0] d1, d2, d3, d6;
      d1 = {32{8'hA5}};
      d2 = {8{32'h0123_4567}};
      d3 = {16{16'h3C3C}};
      d6 = {4{64'h0123_4567_89AB_CDEF}};

      rst_n = 1'b0; axi_awvalid = 1'b0; axi_awaddr = '0; axi_wvalid = 1'b0;
      axi_wdata = '0; axi_wstrb = '1; axi_bready = 1'b0; umi_ready = 1'b0;
      tick(); tick();
      chk("rst_awready", 512'(axi_awready), 512'(1'b0));
      chk("rst_wready", 512'(axi_wready), 512'(1'b0));
      chk("rst_umi_valid", 512'(umi_valid), 512'(1'b0));
      chk("rst_bvalid", 512'(axi_bvalid), 512'(1'b0));
      chk("rst_bresp", 512'(axi_bresp), 512'(2'b00));
      rst_n = 1'b1;
      tick();
      chk("post_rst_awready", 512'(axi_awready), 512'(1'b1));
      chk("post_rst_wready", 512'(axi_wready), 512'(1'b1));

      // 1: AW+W in the same cycle
      umi_ready = 1'b1;
      start_write(64'h1000, d1);
      chk("t1_umi_valid", 512'(umi_valid), 512'(1'b1));
      chk("t1_awready", 512'(axi_awready), 512'(1'b0));
      chk("t1_wready", 512'(axi_wready), 512'(1'b0));
      chk("t1_packet", 512'(umi_packet), 512'(pkt(64'h1000, d1)));
      tick();
      chk("t1_umi_valid_drop", 512'(umi_valid), 512'(1'b0));
      chk("t1_bvalid", 512'(axi_bvalid), 512'(1'b1));
      chk("t1_bresp", 512'(axi_bresp), 512'(2'b00));
      finish_b("t1");

      // 2: W at cycle 0, AW at cycle 3
      axi_awaddr = 64'hDEAD;
      axi_wvalid = 1'b1; axi_wdata = d2;
      tick();
      axi_wvalid = 1'b0; axi_wdata = '0;
      chk("t2_wready_c1", 512'(axi_wready), 512'(1'b0));
      chk("t2_awready_c1", 512'(axi_awready), 512'(1'b1));
      chk("t2_umi_valid_c1", 512'(umi_valid), 512'(1'b0));
      tick();
      chk("t2_umi_valid_c2", 512'(umi_valid), 512'(1'b0));
      chk("t2_wready_c2", 512'(axi_wready), 512'(1'b0));
      tick();
      chk("t2_umi_valid_c3", 512'(umi_valid), 512'(1'b0));
      axi_awvalid = 1'b1; axi_awaddr = 64'h2000;
      tick();
      axi_awvalid = 1'b0; axi_awaddr = 64'hBEEF;
      $display("write addr=0000000000002000 via split AW/W");
      chk("t2_umi_valid_c4", 512'(umi_valid), 512'(1'b1));
      chk("t2_packet", 512'(umi_packet), 512'(pkt(64'h2000, d2)));
      tick();
      chk("t2_bvalid", 512'(axi_bvalid), 512'(1'b1));
      finish_b("t2");

      // 3: umi_ready low for 10 cycles in SEND
      umi_ready = 1'b0;
      start_write(64'h3000, d3);
      chk("t3_umi_valid", 512'(umi_valid), 512'(1'b1));
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_hold_valid", 512'(umi_valid), 512'(1'b1));
         chk("t3_hold_packet", 512'(umi_packet), 512'(pkt(64'h3000, d3)));
         chk("t3_hold_ready", 512'({axi_bvalid, axi_awready, axi_wready}), 512'(3'b000));
      end
      umi_ready = 1'b1;
      tick();
      chk("t3_bvalid", 512'(axi_bvalid), 512'(1'b1));
      chk("t3_umi_valid_drop", 512'(umi_valid), 512'(1'b0));

      // 5: bready low for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_bvalid_hold", 512'(axi_bvalid), 512'(1'b1));
         chk("t5_bresp_hold", 512'(axi_bresp), 512'(2'b00));
         chk("t5_awready_low", 512'(axi_awready), 512'(1'b0));
      end
      finish_b("t5");

      // 4: partial strobes produce SLVERR and no packet
      axi_wstrb = 32'h0000_FFFF;
      start_write(64'h4000, d1);
      chk("t4_umi_valid", 512'(umi_valid), 512'(1'b0));
      chk("t4_bvalid", 512'(axi_bvalid), 512'(1'b1));
      chk("t4_bresp", 512'(axi_bresp), 512'(2'b10));
      tick();
      chk("t4_umi_valid_hold", 512'(umi_valid), 512'(1'b0));
      chk("t4_bresp_hold", 512'(axi_bresp), 512'(2'b10));
      finish_b("t4");
      axi_wstrb = '1;

      // 6: reset during SEND
      umi_ready = 1'b0;
      start_write(64'h5000, d3);
      chk("t6_umi_valid", 512'(umi_valid), 512'(1'b1));
      rst_n = 1'b0;
      tick();
      chk("t6_rst_umi_valid", 512'(umi_valid), 512'(1'b0));
      chk("t6_rst_bvalid", 512'(axi_bvalid), 512'(1'b0));
      chk("t6_rst_ready", 512'({axi_awready, axi_wready}), 512'(2'b00));
      rst_n = 1'b1;
      tick();
      chk("t6_awready", 512'(axi_awready), 512'(1'b1));
      chk("t6_wready", 512'(axi_wready), 512'(1'b1));
      chk("t6_no_bvalid", 512'(axi_bvalid), 512'(1'b0));
      umi_ready = 1'b1;
      start_write(64'h6000, d6);
      chk("t6_new_valid", 512'(umi_valid), 512'(1'b1));
      chk("t6_new_packet", 512'(umi_packet), 512'(pkt(64'h6000, d6)));
      tick();
      chk("t6_new_bvalid", 512'(axi_bvalid), 512'(1'b1));
      chk("t6_new_bresp", 512'(axi_bresp), 512'(2'b00));
      finish_b("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
